turn_scheduler: RTL

// Turn sequencer for the battleship game. Alternates player and PC turns and enables

---
 rtl/turn_scheduler_if.sv | 51 +++++
 rtl/turn_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : turn_scheduler_if
// Description : Signal bundle between the battleship turn scheduler and its
//               environment: game start, cursor selection, PC target, the
//               shared attack engine handshake, and the display/status outputs.
//               modport master : scheduler side (drives attack/status outputs)
//               modport slave  : environment side (drives start/selection/done)
// Revision    : 1.0 - initial release
// ============================================================================
interface turn_scheduler_if;
    // Environment -> scheduler
    logic       start;        // 1-cycle pulse, starts or restarts a game
    logic       sel_valid;    // player confirmed a cell
    logic [2:0] sel_row;      // player row, sampled with sel_valid
    logic [2:0] sel_col;      // player col, sampled with sel_valid
    logic [2:0] pc_row;       // PC target row, sampled when thinking ends
    logic [2:0] pc_col;       // PC target col, sampled when thinking ends
    logic       atk_done;     // attack engine finished the current request
    logic       atk_hit;      // hit flag, valid with atk_done

    // Scheduler -> environment
    logic       sel_enable;   // enables the cursor/selection module
    logic       atk_req;      // attack request to the shared engine
    logic [2:0] atk_row;      // target row, stable while atk_req=1
    logic [2:0] atk_col;      // target col, stable while atk_req=1
    logic       atk_target;   // 0 = PC board, 1 = player board
    logic       player_turn;  // 1 = player's turn
    logic [4:0] player_life;  // remaining player life
    logic [4:0] pc_life;      // remaining PC life
    logic       vga_update;   // 1-cycle pulse after each resolved turn
    logic       game_over;    // game finished
    logic       player_won;   // valid when game_over=1

    modport master (
        input  start, sel_valid, sel_row, sel_col, pc_row, pc_col,
               atk_done, atk_hit,
        output sel_enable, atk_req, atk_row, atk_col, atk_target,
               player_turn, player_life, pc_life, vga_update,
               game_over, player_won
    );

    modport slave (
        output start, sel_valid, sel_row, sel_col, pc_row, pc_col,
               atk_done, atk_hit,
        input  sel_enable, atk_req, atk_row, atk_col, atk_target,
               player_turn, player_life, pc_life, vga_update,
               game_over, player_won
    );
endinterface
`default_nettype wire

// File: rtl/turn_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : turn_scheduler
// Description : Battleship turn sequencer. Alternates player and PC turns,
//               enables cursor selection during the player's turn, enforces
//               the player turn timeout and the PC think delay, issues one
//               attack per turn to a shared engine (req/done handshake),
//               tracks both life counters and declares the winner.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active-low
//               bus  - turn_scheduler_if.master (selection, PC target,
//                      attack handshake, lives, display/status flags)
// Revision    : 1.0 - initial release
// ============================================================================
module turn_scheduler #(
    parameter int BOARD_N          = 5,
    parameter int INIT_LIFE        = 15,
    parameter int TURN_TIMEOUT_CYC = 750000000,
    parameter int PC_THINK_CYC     = 50000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    turn_scheduler_if.master    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int C_TIMER_MAX = (TURN_TIMEOUT_CYC > PC_THINK_CYC) ?
                                 TURN_TIMEOUT_CYC : PC_THINK_CYC;
    localparam int C_TIMER_W   = (C_TIMER_MAX > 1) ? $clog2(C_TIMER_MAX) : 1;

    localparam logic [C_TIMER_W-1:0] C_TURN_LAST  = C_TIMER_W'(TURN_TIMEOUT_CYC - 1);
    localparam logic [C_TIMER_W-1:0] C_THINK_LAST = C_TIMER_W'(PC_THINK_CYC - 1);
    localparam logic [C_TIMER_W-1:0] C_TIMER_ONE  = C_TIMER_W'(1);
    localparam logic [4:0]           C_INIT_LIFE  = 5'(INIT_LIFE);
    localparam int unsigned          C_BOARD_N    = BOARD_N;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_P_SELECT  = 3'd1;
    localparam logic [2:0] S_P_ATTACK  = 3'd2;
    localparam logic [2:0] S_PC_THINK  = 3'd3;
    localparam logic [2:0] S_PC_ATTACK = 3'd4;
    localparam logic [2:0] S_UPDATE    = 3'd5;
    localparam logic [2:0] S_GAME_OVER = 3'd6;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           state_q,       state_d;
    logic [C_TIMER_W-1:0] timer_q,       timer_d;
    logic [2:0]           row_q,         row_d;
    logic [2:0]           col_q,         col_d;
    logic                 target_q,      target_d;
    logic                 req_q,         req_d;
    logic                 turn_q,        turn_d;
    logic [4:0]           player_life_q, player_life_d;
    logic [4:0]           pc_life_q,     pc_life_d;
    logic                 won_q,         won_d;

    logic                 w_sel_ok;
    logic                 w_pc_ok;

    function automatic logic in_range(input logic [2:0] r, input logic [2:0] c);
        return (32'(r) < C_BOARD_N) && (32'(c) < C_BOARD_N);
    endfunction

    assign w_sel_ok = bus.sel_valid && in_range(bus.sel_row, bus.sel_col);
    assign w_pc_ok  = in_range(bus.pc_row, bus.pc_col);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; req_q clears asynchronously so a reset during an
    // attack withdraws the request in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q       <= '0;
            row_q         <= '0;
            col_q         <= '0;
            target_q      <= 1'b0;
            req_q         <= 1'b0;
            turn_q        <= 1'b1;
            player_life_q <= C_INIT_LIFE;
            pc_life_q     <= C_INIT_LIFE;
            won_q         <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            row_q         <= row_d;
            col_q         <= col_d;
            target_q      <= target_d;
            req_q         <= req_d;
            turn_q        <= turn_d;
            player_life_q <= player_life_d;
            pc_life_q     <= pc_life_d;
            won_q         <= won_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        row_d         = row_q;
        col_d         = col_q;
        target_d      = target_q;
        req_d         = 1'b0;
        turn_d        = turn_q;
        player_life_d = player_life_q;
        pc_life_d     = pc_life_q;
        won_d         = won_q;

        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                // Both idle states accept start; sel_valid/atk_done ignored.
                if (bus.start) begin
                    state_d       = S_P_SELECT;
                    timer_d       = '0;
                    turn_d        = 1'b1;
                    player_life_d = C_INIT_LIFE;
                    pc_life_d     = C_INIT_LIFE;
                    won_d         = 1'b0;
                end
            end

            S_P_SELECT: begin
                // A valid selection on the timeout cycle takes priority.
                if (w_sel_ok) begin
                    state_d  = S_P_ATTACK;
                    timer_d  = '0;
                    row_d    = bus.sel_row;
                    col_d    = bus.sel_col;
                    target_d = 1'b0;
                end else if (timer_q == C_TURN_LAST) begin
                    state_d = S_UPDATE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + C_TIMER_ONE;
                end
            end

            S_P_ATTACK, S_PC_ATTACK: begin
                // req_q is low on the entry cycle, so a done is only honoured
                // once the request is actually on the wire.
                if (req_q && bus.atk_done) begin
                    state_d = S_UPDATE;
                    if (bus.atk_hit) begin
                        if (state_q == S_P_ATTACK) begin
                            if (pc_life_q != 5'd0) begin
                                pc_life_d = pc_life_q - 5'd1;
                            end
                        end else begin
                            if (player_life_q != 5'd0) begin
                                player_life_d = player_life_q - 5'd1;
                            end
                        end
                    end
                end else begin
                    req_d = 1'b1;
                end
            end

            S_PC_THINK: begin
                // Timer holds at the last count while the PC target is out of
                // range, so the target is resampled every following cycle.
                if (timer_q == C_THINK_LAST) begin
                    if (w_pc_ok) begin
                        state_d  = S_PC_ATTACK;
                        timer_d  = '0;
                        row_d    = bus.pc_row;
                        col_d    = bus.pc_col;
                        target_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + C_TIMER_ONE;
                end
            end

            S_UPDATE: begin
                if ((player_life_q == 5'd0) || (pc_life_q == 5'd0)) begin
                    state_d = S_GAME_OVER;
                    won_d   = (pc_life_q == 5'd0);
                end else begin
                    turn_d  = ~turn_q;
                    state_d = turn_q ? S_PC_THINK : S_P_SELECT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.sel_enable  = (state_q == S_P_SELECT);
        bus.vga_update  = (state_q == S_UPDATE);
        bus.game_over   = (state_q == S_GAME_OVER);
        bus.player_won  = won_q;
        bus.atk_req     = req_q;
        bus.atk_row     = row_q;
        bus.atk_col     = col_q;
        bus.atk_target  = target_q;
        bus.player_turn = turn_q;
        bus.player_life = player_life_q;
        bus.pc_life     = pc_life_q;
    end

endmodule
`default_nettype wire
